mmu_arbiter: RTL and testbench
==============================

Name: mmu_arbiter

Overview:
- Two-port arbiter that shares the single mmu request interface between the cpu instruction-fetch path (I port, read-only, word) and the load/store path (D port, full attributes).
- Sits between cpu and mmu inside soc; mmu-side ports map one-to-one onto mmu write_enable/read_enable/mem_signed_read/mem_data_width/address/data_in/data_out/mem_ready.
- Round-robin on simultaneous requests, one outstanding mmu transaction, per-port completion pulse, optional watchdog timeout with error flag.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles in BUSY waiting for mmu_mem_ready; 0 disables watchdog.
- CNT_W, 16, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- i_req  in  1  fetch request, held until i_ready
- i_address  in  32  fetch address
- i_ready  out  1  one-cycle completion pulse, I port
- i_data_out  out  32  fetched word, valid while i_ready=1, held afterwards
- i_error  out  1  valid with i_ready; 1 = watchdog timeout
- d_req  in  1  data request, held until d_ready
- d_write_enable  in  1  1 = store, 0 = load
- d_signed_read  in  1  sign-extend load
- d_data_width  in  2  00 byte, 01 half, 10 word
- d_address  in  32  data address
- d_data_in  in  32  store data
- d_ready  out  1  one-cycle completion pulse, D port
- d_data_out  out  32  load data, valid while d_ready=1, held afterwards
- d_error  out  1  valid with d_ready; 1 = watchdog timeout
- grant_d  out  1  current/last owner: 1 = D, 0 = I
- mmu_read_enable  out  1  to mmu read_enable
- mmu_write_enable  out  1  to mmu write_enable
- mmu_signed_read  out  1  to mmu mem_signed_read
- mmu_data_width  out  2  to mmu mem_data_width
- mmu_address  out  32  to mmu address
- mmu_data_in  out  32  to mmu data_in
- mmu_mem_ready  in  1  from mmu mem_ready
- mmu_data_out  in  32  from mmu data_out

Behaviour:
- Single clock, clk rising edge; reset synchronous, active-low (reset_n=0 sampled at edge). All outputs registered.
- Reset values: all outputs 0; state IDLE; last_grant=I (so D wins first tie); watchdog count 0. Reset mid-BUSY abandons transaction: no ready pulse, enables drop after the reset edge.
- States: IDLE, BUSY, DONE.
- IDLE: no req -> stay. Only one req -> grant it. Both -> grant port != last_grant. On grant: latch attributes into mmu_* regs; assert mmu_read_enable (I, or D load) or mmu_write_enable (D store); I fetch forces width 10, signed 0, data_in 0; set grant_d; clear count; -> BUSY.
- BUSY: mmu_* outputs held stable, enable held high. mmu_mem_ready=1 -> capture mmu_data_out into granted port's data_out (store: captured too), error=0, drop enables, last_grant <= granted port -> DONE. Else count++; if TIMEOUT_CYCLES!=0 and count == TIMEOUT_CYCLES-1 -> drop enables, error=1, data_out=0 -> DONE.
- DONE: granted port's ready=1 for exactly this cycle; reqs ignored (no double-issue while requester drops req); -> IDLE. mmu_mem_ready in DONE/IDLE ignored.
- Latency: req sampled at edge k -> enable high after k; mem_ready sampled at edge k+m (m>=1) -> ready high after k+m for 1 cycle. Min 3 cycles req-to-next-issue; max throughput one transaction per 3 cycles with mem_ready in first BUSY cycle.
- Fairness: with both reqs continuously high, grants strictly alternate D, I, D, I...
- Request attributes sampled only at grant; changes while BUSY have no effect.
- Neither enable is ever asserted outside BUSY; both never high together.

Decomposition:
- Package mmu_arb_pkg: state encoding (IDLE/BUSY/DONE), width codes WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10, PORT_I=0/PORT_D=1.
- Natural sub-module: rr_arbiter2 (combinational 2-way round-robin pick from two reqs + last_grant). Watchdog stays inline.

Test Plan:
- I only: i_req=1, i_address=0x100, mmu returns 0x00A00093 with mem_ready 2 cycles after enable -> mmu_read_enable=1, width 10, signed 0, address 0x100 for 2 cycles; i_ready pulse 1 cycle, i_data_out=0x00A00093, i_error=0.
- D store: d_req, write 1, width 00, address 0x2004, data_in 0xAB -> mmu_write_enable=1, read_enable=0, mmu_data_in=0xAB; d_ready single pulse; i_ready stays 0.
- Tie after reset: both reqs high continuously for 4 transactions, mem_ready 1 cycle -> grant order D,I,D,I; each ready pulse exactly once; enables never both high.
- Timeout: TIMEOUT_CYCLES=8, D load, mem_ready never -> enable high 8 cycles, then d_ready=1, d_error=1, d_data_out=0; next request serviced normally.
- Reset mid-BUSY: reset_n=0 for one edge during BUSY, then mem_ready=1 -> all outputs 0 after reset edge, no ready pulse, state IDLE; fresh D-first tie afterwards.
- Held req: requester keeps i_req high one cycle past i_ready -> DONE ignores it; exactly one new transaction issued from IDLE.

Source files
------------

// File: rtl/mmu_arb_pkg.sv
// rtl/mmu_arb_pkg.sv - shared constants for the two-port mmu arbiter
package mmu_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mmu_arbiter_if.sv
// rtl/mmu_arbiter_if.sv - cpu-side request ports and mmu-side bus of the arbiter
interface mmu_arbiter_if;

    logic        i_req;
    logic [31:0] i_address;
    logic        i_ready;
    logic [31:0] i_data_out;
    logic        i_error;

    logic        d_req;
    logic        d_write_enable;
    logic        d_signed_read;
    logic [1:0]  d_data_width;
    logic [31:0] d_address;
    logic [31:0] d_data_in;
    logic        d_ready;
    logic [31:0] d_data_out;
    logic        d_error;

    logic        grant_d;

    logic        mmu_read_enable;
    logic        mmu_write_enable;
    logic        mmu_signed_read;
    logic [1:0]  mmu_data_width;
    logic [31:0] mmu_address;
    logic [31:0] mmu_data_in;
    logic        mmu_mem_ready;
    logic [31:0] mmu_data_out;

    // arbiter view
    modport master (
        input  i_req, i_address,
        input  d_req, d_write_enable, d_signed_read, d_data_width, d_address, d_data_in,
        input  mmu_mem_ready, mmu_data_out,
        output i_ready, i_data_out, i_error,
        output d_ready, d_data_out, d_error,
        output grant_d,
        output mmu_read_enable, mmu_write_enable, mmu_signed_read, mmu_data_width,
        output mmu_address, mmu_data_in
    );

    // cpu + mmu environment view
    modport slave (
        output i_req, i_address,
        output d_req, d_write_enable, d_signed_read, d_data_width, d_address, d_data_in,
        output mmu_mem_ready, mmu_data_out,
        input  i_ready, i_data_out, i_error,
        input  d_ready, d_data_out, d_error,
        input  grant_d,
        input  mmu_read_enable, mmu_write_enable, mmu_signed_read, mmu_data_width,
        input  mmu_address, mmu_data_in
    );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin pick
module rr_arbiter2
    import mmu_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic valid,
    output logic pick_d
);

    // on a tie the port that did not complete last wins
    always_comb begin
        valid  = req_i | req_d;
        pick_d = req_d & (~req_i | (last_grant == PORT_I));
    end

endmodule

// File: rtl/mmu_arbiter.sv
// rtl/mmu_arbiter.sv - shares one mmu request bus between fetch and load/store ports
module mmu_arbiter
    import mmu_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    mmu_arbiter_if.master bus
);

    localparam bit             WDOG_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LIMIT =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             grant_d_q, grant_d_d;
    logic             re_q, re_d;
    logic             we_q, we_d;
    logic             signed_q, signed_d;
    logic [1:0]       width_q, width_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             i_ready_q, i_ready_d;
    logic [31:0]      i_data_q, i_data_d;
    logic             i_error_q, i_error_d;
    logic             d_ready_q, d_ready_d;
    logic [31:0]      d_data_q, d_data_d;
    logic             d_error_q, d_error_d;

    logic pick_valid;
    logic pick_d;

    rr_arbiter2 u_rr (
        .req_i      (bus.i_req),
        .req_d      (bus.d_req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .pick_d     (pick_d)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        grant_d_d    = grant_d_q;
        re_d         = re_q;
        we_d         = we_q;
        signed_d     = signed_q;
        width_d      = width_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_ready_d    = 1'b0;
        i_data_d     = i_data_q;
        i_error_d    = i_error_q;
        d_ready_d    = 1'b0;
        d_data_d     = d_data_q;
        d_error_d    = d_error_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d_d = pick_d;
                    count_d   = '0;
                    state_d   = ST_BUSY;
                    if (pick_d) begin
                        re_d     = ~bus.d_write_enable;
                        we_d     = bus.d_write_enable;
                        signed_d = bus.d_signed_read;
                        width_d  = bus.d_data_width;
                        addr_d   = bus.d_address;
                        wdata_d  = bus.d_data_in;
                    end else begin
                        // fetches are always unsigned word reads
                        re_d     = 1'b1;
                        we_d     = 1'b0;
                        signed_d = 1'b0;
                        width_d  = WIDTH_WORD;
                        addr_d   = bus.i_address;
                        wdata_d  = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.mmu_mem_ready) begin
                    re_d         = 1'b0;
                    we_d         = 1'b0;
                    last_grant_d = grant_d_q;
                    state_d      = ST_DONE;
                    if (grant_d_q) begin
                        d_ready_d = 1'b1;
                        d_data_d  = bus.mmu_data_out;
                        d_error_d = 1'b0;
                    end else begin
                        i_ready_d = 1'b1;
                        i_data_d  = bus.mmu_data_out;
                        i_error_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                    // old count reaching the limit means the enable has been
                    // high for exactly TIMEOUT_CYCLES cycles
                    if (WDOG_EN && count_q == TO_LIMIT) begin
                        re_d    = 1'b0;
                        we_d    = 1'b0;
                        state_d = ST_DONE;
                        if (grant_d_q) begin
                            d_ready_d = 1'b1;
                            d_data_d  = '0;
                            d_error_d = 1'b1;
                        end else begin
                            i_ready_d = 1'b1;
                            i_data_d  = '0;
                            i_error_d = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                // requests are ignored here so a requester still holding
                // req during its ready pulse is not issued twice
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                re_d    = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_I;
            count_q      <= '0;
            grant_d_q    <= 1'b0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            width_q      <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_ready_q    <= 1'b0;
            i_data_q     <= '0;
            i_error_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            d_data_q     <= '0;
            d_error_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            grant_d_q    <= grant_d_d;
            re_q         <= re_d;
            we_q         <= we_d;
            signed_q     <= signed_d;
            width_q      <= width_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_ready_q    <= i_ready_d;
            i_data_q     <= i_data_d;
            i_error_q    <= i_error_d;
            d_ready_q    <= d_ready_d;
            d_data_q     <= d_data_d;
            d_error_q    <= d_error_d;
        end
    end

    assign bus.grant_d          = grant_d_q;
    assign bus.mmu_read_enable  = re_q;
    assign bus.mmu_write_enable = we_q;
    assign bus.mmu_signed_read  = signed_q;
    assign bus.mmu_data_width   = width_q;
    assign bus.mmu_address      = addr_q;
    assign bus.mmu_data_in      = wdata_q;
    assign bus.i_ready          = i_ready_q;
    assign bus.i_data_out       = i_data_q;
    assign bus.i_error          = i_error_q;
    assign bus.d_ready          = d_ready_q;
    assign bus.d_data_out       = d_data_q;
    assign bus.d_error          = d_error_q;

endmodule

// File: tb/tb_mmu_arbiter.sv
// tb/tb_mmu_arbiter.sv - self-checking bench for mmu_arbiter
module tb_mmu_arbiter;
    import mmu_arb_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mmu_arbiter_if bus ();

    mmu_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // mmu responder: answers after cur_lat enabled cycles (0 = never)
    int          mem_lat   = 1;
    bit          lat_rand  = 1'b0;
    bit          fixed_en  = 1'b1;
    logic [31:0] fixed_val = 32'h00A00093;
    logic        mem_force = 1'b0;
    int          busy_cnt  = 0;
    int          cur_lat   = 0;
    logic [31:0] resp      = '0;
    bit          rand_done = 1'b0;

    always @(posedge clk) begin
        #2;
        bus.mmu_data_out = $urandom;
        if (bus.mmu_read_enable || bus.mmu_write_enable) begin
            if (busy_cnt == 0) cur_lat = lat_rand ? int'($urandom_range(1, 4)) : mem_lat;
            busy_cnt++;
            if (cur_lat != 0 && busy_cnt == cur_lat) begin
                resp = fixed_en ? fixed_val : $urandom;
                bus.mmu_data_out = resp;
                bus.mmu_mem_ready = 1'b1;
            end else begin
                bus.mmu_mem_ready = mem_force;
            end
        end else begin
            busy_cnt = 0;
            bus.mmu_mem_ready = mem_force;
        end
    end

    function automatic logic [137:0] all_outs();
        return {bus.i_ready, bus.i_data_out, bus.i_error, bus.d_ready, bus.d_data_out,
                bus.d_error, bus.grant_d, bus.mmu_read_enable, bus.mmu_write_enable,
                bus.mmu_signed_read, bus.mmu_data_width, bus.mmu_address, bus.mmu_data_in};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.i_req = 0; bus.i_address = 0;
        bus.d_req = 0; bus.d_write_enable = 0; bus.d_signed_read = 0;
        bus.d_data_width = 0; bus.d_address = 0; bus.d_data_in = 0;
        reset_n = 1'b0;
        repeat (3) tick();
        total++;
        if (all_outs() !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", all_outs());
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (all_outs() !== '0) begin
            bad++; $display("FAIL idle_no_req got=%h want=0", all_outs());
        end
    endtask

    task automatic test_i_only();
        int en_cyc = 0;
        int rdy = 0;
        bit attr_ok = 1'b1;
        mem_lat = 2; fixed_en = 1'b1; fixed_val = 32'h00A00093;
        bus.i_req = 1'b1; bus.i_address = 32'h100;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.mmu_read_enable) begin
                en_cyc++;
                if (bus.mmu_write_enable || bus.mmu_data_width !== WIDTH_WORD || bus.mmu_signed_read ||
                    bus.mmu_address !== 32'h100 || bus.mmu_data_in !== 0 || bus.grant_d) attr_ok = 1'b0;
            end
            if (bus.i_ready) begin
                rdy++;
                total++;
                if (bus.i_data_out !== 32'h00A00093) begin
                    bad++; $display("FAIL i_only_data got=%h want=00a00093", bus.i_data_out);
                end
                total++;
                if (bus.i_error !== 1'b0) begin
                    bad++; $display("FAIL i_only_error got=%b want=0", bus.i_error);
                end
                bus.i_req = 1'b0;
            end
        end
        total++;
        if (en_cyc != 2) begin bad++; $display("FAIL i_only_enable_cycles got=%0d want=2", en_cyc); end
        total++;
        if (rdy != 1) begin bad++; $display("FAIL i_only_ready_pulses got=%0d want=1", rdy); end
        total++;
        if (!attr_ok) begin bad++; $display("FAIL i_only_attributes got=bad want=word_read_0x100"); end
        total++;
        if (bus.i_data_out !== 32'h00A00093) begin
            bad++; $display("FAIL i_only_data_held got=%h want=00a00093", bus.i_data_out);
        end
    endtask

    task automatic test_d_store();
        int we_cyc = 0;
        int rdy = 0;
        int irdy = 0;
        bit attr_ok = 1'b1;
        mem_lat = 1; fixed_val = 32'h5A5A0001;
        bus.d_req = 1'b1; bus.d_write_enable = 1'b1; bus.d_signed_read = 1'b0;
        bus.d_data_width = WIDTH_BYTE; bus.d_address = 32'h2004; bus.d_data_in = 32'hAB;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.mmu_read_enable) attr_ok = 1'b0;
            if (bus.mmu_write_enable) begin
                we_cyc++;
                if (bus.mmu_data_in !== 32'hAB || bus.mmu_address !== 32'h2004 ||
                    bus.mmu_data_width !== WIDTH_BYTE || !bus.grant_d) attr_ok = 1'b0;
            end
            if (bus.i_ready) irdy++;
            if (bus.d_ready) begin
                rdy++;
                total++;
                if (bus.d_data_out !== 32'h5A5A0001 || bus.d_error !== 1'b0) begin
                    bad++; $display("FAIL d_store_capture got=%h/%b want=5a5a0001/0", bus.d_data_out, bus.d_error);
                end
                bus.d_req = 1'b0;
            end
        end
        total++;
        if (we_cyc != 1) begin bad++; $display("FAIL d_store_we_cycles got=%0d want=1", we_cyc); end
        total++;
        if (!attr_ok) begin bad++; $display("FAIL d_store_attributes got=bad want=store_0xab_0x2004"); end
        total++;
        if (rdy != 1 || irdy != 0) begin
            bad++; $display("FAIL d_store_ready got=d%0d/i%0d want=d1/i0", rdy, irdy);
        end
    endtask

    task automatic test_tie();
        logic [3:0] order = '0;
        int n_iss = 0;
        int n_rdy = 0;
        int i_rdy = 0;
        int d_rdy = 0;
        int both = 0;
        logic prev_en = 1'b0;
        do_reset();
        mem_lat = 1;
        bus.i_req = 1'b1; bus.i_address = 32'h40;
        bus.d_req = 1'b1; bus.d_write_enable = 1'b0; bus.d_data_width = WIDTH_WORD;
        bus.d_address = 32'h80; bus.d_data_in = 32'h0;
        for (int c = 0; c < 22; c++) begin
            tick();
            if (bus.mmu_read_enable && bus.mmu_write_enable) both++;
            if (bus.mmu_read_enable && !prev_en) begin
                n_iss++;
                order = {order[2:0], bus.grant_d};
            end
            prev_en = bus.mmu_read_enable;
            if (bus.i_ready) i_rdy++;
            if (bus.d_ready) d_rdy++;
            if (bus.i_ready || bus.d_ready) begin
                n_rdy++;
                total++;
                if (bus.d_ready !== bus.grant_d || bus.i_ready === bus.d_ready) begin
                    bad++; $display("FAIL tie_ready_port got=i%b/d%b want=grant_d=%b", bus.i_ready, bus.d_ready, bus.grant_d);
                end
                if (n_rdy == 4) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
            end
        end
        total++;
        if (n_iss != 4 || order !== 4'b1010) begin
            bad++; $display("FAIL tie_grant_order got=%0d/%b want=4/1010", n_iss, order);
        end
        total++;
        if (i_rdy != 2 || d_rdy != 2) begin
            bad++; $display("FAIL tie_ready_counts got=i%0d/d%0d want=i2/d2", i_rdy, d_rdy);
        end
        total++;
        if (both != 0) begin bad++; $display("FAIL tie_both_enables got=%0d want=0", both); end
    endtask

    task automatic test_timeout();
        int en_cyc = 0;
        int rdy = 0;
        bit ok2 = 1'b0;
        mem_lat = 0;
        bus.d_req = 1'b1; bus.d_write_enable = 1'b0; bus.d_data_width = WIDTH_WORD;
        bus.d_address = 32'h3000;
        for (int c = 0; c < 20 && rdy == 0; c++) begin
            tick();
            if (bus.mmu_read_enable) en_cyc++;
            if (bus.d_ready) begin
                rdy++;
                total++;
                if (bus.d_error !== 1'b1 || bus.d_data_out !== 32'h0) begin
                    bad++; $display("FAIL timeout_flag got=%b/%h want=1/00000000", bus.d_error, bus.d_data_out);
                end
                bus.d_req = 1'b0;
            end
        end
        total++;
        if (en_cyc != 8 || rdy != 1) begin
            bad++; $display("FAIL timeout_enable_cycles got=%0d/%0d want=8/1", en_cyc, rdy);
        end
        tick();
        mem_lat = 1; fixed_val = 32'hC0DE0042;
        bus.d_req = 1'b1; bus.d_address = 32'h3004;
        for (int c = 0; c < 10 && !ok2; c++) begin
            tick();
            if (bus.d_ready) begin
                ok2 = 1'b1;
                total++;
                if (bus.d_error !== 1'b0 || bus.d_data_out !== 32'hC0DE0042) begin
                    bad++; $display("FAIL timeout_recover got=%b/%h want=0/c0de0042", bus.d_error, bus.d_data_out);
                end
                bus.d_req = 1'b0;
            end
        end
        total++;
        if (!ok2) begin bad++; $display("FAIL timeout_recover_ready got=none want=pulse"); end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        int spurious = 0;
        logic [1:0] order = '0;
        int n_iss = 0;
        int n_rdy = 0;
        logic prev_en = 1'b0;
        mem_lat = 0;
        bus.d_req = 1'b1; bus.d_write_enable = 1'b0; bus.d_address = 32'h4000;
        repeat (3) tick();
        total++;
        if (bus.mmu_read_enable !== 1'b1) begin
            bad++; $display("FAIL midbusy_enable got=%b want=1", bus.mmu_read_enable);
        end
        reset_n = 1'b0; mem_force = 1'b1;
        tick();
        total++;
        if (all_outs() !== '0) begin
            bad++; $display("FAIL midbusy_reset_outputs got=%h want=0", all_outs());
        end
        reset_n = 1'b1; bus.d_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.i_ready || bus.d_ready || bus.mmu_read_enable || bus.mmu_write_enable) spurious++;
        end
        total++;
        if (spurious != 0) begin bad++; $display("FAIL midbusy_after_reset got=%0d want=0", spurious); end
        mem_force = 1'b0; mem_lat = 1;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.mmu_read_enable && !prev_en) begin
                n_iss++;
                order = {order[0], bus.grant_d};
            end
            prev_en = bus.mmu_read_enable;
            if (bus.i_ready || bus.d_ready) begin
                n_rdy++;
                if (n_rdy == 2) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
            end
        end
        total++;
        if (n_iss != 2 || order !== 2'b10) begin
            bad++; $display("FAIL midbusy_fresh_tie got=%0d/%b want=2/10", n_iss, order);
        end
    endtask

    task automatic test_held_req();
        bit got = 1'b0;
        int rise = 0;
        int rdy = 0;
        logic prev_en;
        mem_lat = 1;
        bus.i_req = 1'b1; bus.i_address = 32'h200;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (bus.i_ready) got = 1'b1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL held_first_ready got=none want=pulse"); end
        tick();
        total++;
        if (bus.mmu_read_enable !== 1'b0) begin
            bad++; $display("FAIL held_done_ignores got=%b want=0", bus.mmu_read_enable);
        end
        tick();
        total++;
        if (bus.mmu_read_enable !== 1'b1) begin
            bad++; $display("FAIL held_idle_issues got=%b want=1", bus.mmu_read_enable);
        end
        bus.i_req = 1'b0;
        prev_en = bus.mmu_read_enable;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.mmu_read_enable && !prev_en) rise++;
            prev_en = bus.mmu_read_enable;
            if (bus.i_ready) rdy++;
        end
        total++;
        if (rise != 0 || rdy != 1) begin
            bad++; $display("FAIL held_single_txn got=extra%0d/rdy%0d want=0/1", rise, rdy);
        end
    endtask

    task automatic req_i_proc(input int n);
        for (int t = 0; t < n; t++) begin
            bit got = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #3;
            bus.i_req = 1'b1; bus.i_address = $urandom;
            for (int w = 0; w < 60 && !got; w++) begin
                @(posedge clk); #3;
                if (bus.i_ready) got = 1'b1;
                else bus.i_address = $urandom;
            end
            total++;
            if (!got) begin bad++; $display("FAIL rand_i_wait got=timeout want=ready"); end
            bus.i_req = 1'b0;
        end
    endtask

    task automatic req_d_proc(input int n);
        for (int t = 0; t < n; t++) begin
            bit got = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #3;
            bus.d_req = 1'b1;
            for (int w = 0; w < 60 && !got; w++) begin
                if (w > 0) begin
                    @(posedge clk); #3;
                    if (bus.d_ready) got = 1'b1;
                end
                if (!got) begin
                    bus.d_write_enable = $urandom_range(0, 1);
                    bus.d_signed_read = $urandom_range(0, 1);
                    bus.d_data_width = 2'($urandom_range(0, 2));
                    bus.d_address = $urandom;
                    bus.d_data_in = $urandom;
                end
            end
            total++;
            if (!got) begin bad++; $display("FAIL rand_d_wait got=timeout want=ready"); end
            bus.d_req = 1'b0;
        end
    endtask

    // transaction-level model: an idle arbiter issues to the sampled request
    // (tie goes to the port that did not complete last), holds the latched
    // attributes until the mmu answers, returns that answer on the owner's
    // ready, then ignores requests for one more cycle
    task automatic rand_checker();
        bit          busy_m = 1'b0;
        logic        port_m = PORT_I;
        logic        last_m = PORT_I;
        int          cyc = 0;
        int          free_cyc = 0;
        logic [69:0] exp_attr = '0;
        logic [69:0] got_attr;
        while (!rand_done && cyc < 6000) begin
            tick();
            cyc++;
            got_attr = {bus.mmu_read_enable, bus.mmu_write_enable, bus.mmu_signed_read,
                        bus.mmu_data_width, bus.mmu_address, bus.mmu_data_in, bus.grant_d};
            total++;
            if (bus.mmu_read_enable && bus.mmu_write_enable) begin
                bad++; $display("FAIL rand_both_enables got=11 want=not_both");
            end
            if (!busy_m) begin
                total++;
                if (bus.i_ready || bus.d_ready) begin
                    bad++; $display("FAIL rand_spurious_ready got=i%b/d%b want=0/0", bus.i_ready, bus.d_ready);
                end
                if (cyc >= free_cyc && (bus.i_req || bus.d_req)) begin
                    port_m = bus.d_req && (!bus.i_req || last_m == PORT_I);
                    if (port_m)
                        exp_attr = {!bus.d_write_enable, bus.d_write_enable, bus.d_signed_read,
                                    bus.d_data_width, bus.d_address, bus.d_data_in, 1'b1};
                    else
                        exp_attr = {1'b1, 1'b0, 1'b0, WIDTH_WORD, bus.i_address, 32'h0, 1'b0};
                    busy_m = 1'b1;
                    total++;
                    if (got_attr !== exp_attr) begin
                        bad++; $display("FAIL rand_issue got=%h want=%h", got_attr, exp_attr);
                    end
                end else begin
                    total++;
                    if (bus.mmu_read_enable || bus.mmu_write_enable) begin
                        bad++; $display("FAIL rand_idle_enable got=%b%b want=00", bus.mmu_read_enable, bus.mmu_write_enable);
                    end
                end
            end else if (bus.i_ready || bus.d_ready) begin
                total++;
                if (bus.d_ready !== port_m || bus.i_ready !== !port_m) begin
                    bad++; $display("FAIL rand_ready_port got=i%b/d%b want_port_d=%b", bus.i_ready, bus.d_ready, port_m);
                end
                total++;
                if ((port_m ? {bus.d_data_out, bus.d_error} : {bus.i_data_out, bus.i_error}) !== {resp, 1'b0}) begin
                    bad++; $display("FAIL rand_ready_data got=%h/%h want=%h", bus.i_data_out, bus.d_data_out, resp);
                end
                total++;
                if (bus.mmu_read_enable || bus.mmu_write_enable) begin
                    bad++; $display("FAIL rand_enable_drop got=%b%b want=00", bus.mmu_read_enable, bus.mmu_write_enable);
                end
                busy_m = 1'b0;
                last_m = port_m;
                free_cyc = cyc + 2;
            end else begin
                total++;
                if (got_attr !== exp_attr) begin
                    bad++; $display("FAIL rand_busy_hold got=%h want=%h", got_attr, exp_attr);
                end
            end
        end
        total++;
        if (!rand_done) begin bad++; $display("FAIL rand_run_bound got=timeout want=done"); end
    endtask

    task automatic test_random();
        do_reset();
        lat_rand = 1'b1; fixed_en = 1'b0;
        fork
            begin
                fork
                    req_i_proc(30);
                    req_d_proc(30);
                join
                rand_done = 1'b1;
            end
            rand_checker();
        join
        lat_rand = 1'b0; fixed_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_i_only();
        test_d_store();
        test_tie();
        test_timeout();
        test_reset_mid_busy();
        test_held_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
